sub_chain: RTL and testbench

Parametrised, registered cascade of `STAGES` identical two-lane processing stages, joined by a valid/ready handshake. It replaces the fixed, unclocked two-instance chain with a pipelined chain of any depth and width, with a runtime-selectable combine operation and per-beat mode tagging. It sits between a producer and a consumer that both use valid/ready, and adds full-throughput buffering with backpressure and flush.

---
 rtl/sub_chain.sv | 82 ++++++++
 tb/tb_sub_chain.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sub_chain.sv
// sub_chain: valid/ready pipeline of STAGES two-lane stages; each stage rewrites lane B with the beat's mode op, plus flush and an occupancy count
module sub_chain #(
  parameter int STAGES = 2,
  parameter int W = 8,
  parameter int CNT_W = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] occupancy
);
  logic [STAGES:1] v_q, v_d;
  logic [W-1:0] a_q [1:STAGES];
  logic [W-1:0] a_d [1:STAGES];
  logic [W-1:0] b_q [1:STAGES];
  logic [W-1:0] b_d [1:STAGES];
  logic [1:0] m_q [1:STAGES];
  logic [1:0] m_d [1:STAGES];
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [STAGES+1:1] rdy;
  logic [STAGES:0] sv;
  logic [W-1:0] sa [0:STAGES];
  logic [W-1:0] sb [0:STAGES];
  logic [1:0] sm [0:STAGES];
  int cnt;
  function automatic logic [W-1:0] op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    return m == 2'b00 ? b : m == 2'b01 ? a & b : m == 2'b10 ? a | b : a ^ b;
  endfunction
  always_comb begin
    sv[0] = in_valid;
    sa[0] = in_a;
    sb[0] = in_b;
    sm[0] = in_mode;
    for (int k = 1; k <= STAGES; k++) begin
      sv[k] = v_q[k];
      sa[k] = a_q[k];
      sb[k] = b_q[k];
      sm[k] = m_q[k];
    end
    rdy[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--) rdy[k] = ~v_q[k] | rdy[k+1];
    cnt = 0;
    for (int k = 1; k <= STAGES; k++) begin
      v_d[k] = flush ? 1'b0 : (sv[k-1] & rdy[k]) ? 1'b1 : rdy[k+1] ? 1'b0 : v_q[k];
      a_d[k] = (sv[k-1] & rdy[k]) ? sa[k-1] : a_q[k];
      b_d[k] = (sv[k-1] & rdy[k]) ? op(sm[k-1], sa[k-1], sb[k-1]) : b_q[k];
      m_d[k] = (sv[k-1] & rdy[k]) ? sm[k-1] : m_q[k];
      cnt = cnt + (v_d[k] ? 1 : 0);
    end
    occ_d = cnt > STAGES ? CNT_W'(STAGES) : CNT_W'(cnt);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      occ_q <= '0;
    end else begin
      v_q <= v_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    m_q <= m_d;
  end
  assign in_ready = rdy[1];
  assign out_valid = v_q[STAGES];
  assign out_a = a_q[STAGES];
  assign out_b = b_q[STAGES];
  assign out_mode = m_q[STAGES];
  assign occupancy = occ_q;
endmodule

// File: tb/tb_sub_chain.sv
// tb_sub_chain: directed self-checking bench for sub_chain with STAGES=2, W=8
module tb_sub_chain;
  logic clk = 0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_a, out_b;
  logic [1:0] in_mode, out_mode, occupancy;
  int n_cmp = 0;
  int n_bad = 0;
  sub_chain #(.STAGES(2), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_mode(out_mode), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
    in_valid = v;
    in_a = a;
    in_b = b;
    in_mode = m;
  endtask
  task automatic test_reset;
    rst_n = 0; flush = 0; out_ready = 1; drive(0, 0, 0, 0);
    repeat (3) tick;
    rst_n = 1;
    tick;
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    drive(1, 8'hF0, 8'h3C, 2'b01);
    tick;
    drive(0, 0, 0, 0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_early_valid got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd1) begin n_bad++; $display("FAIL first_occ got %0d want 1", occupancy); end
    tick;
    n_cmp++; if ({out_valid, out_a, out_b, out_mode} !== {1'b1, 8'hF0, 8'h30, 2'b01}) begin n_bad++; $display("FAIL first_beat got v=%b a=%h b=%h m=%b want v=1 a=f0 b=30 m=01", out_valid, out_a, out_b, out_mode); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_drain got %b want 0", out_valid); end
  endtask
  task automatic test_all_modes;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h3C; exp_b[1] = 8'h30; exp_b[2] = 8'hFC; exp_b[3] = 8'h3C;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1, 8'hF0, 8'h3C, 2'(i)); else drive(0, 0, 0, 0);
      tick;
      if (i >= 1) begin
        n_cmp++; if ({out_valid, out_a, out_b, out_mode} !== {1'b1, 8'hF0, exp_b[i-1], 2'(i-1)}) begin n_bad++; $display("FAIL mode_%0d got v=%b a=%h b=%h m=%b want v=1 a=f0 b=%h m=%0d", i-1, out_valid, out_a, out_b, out_mode, exp_b[i-1], i-1); end
      end
    end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL modes_drain got %b want 0", out_valid); end
  endtask
  task automatic test_backpressure;
    out_ready = 0;
    drive(1, 8'h11, 8'h22, 2'b00);
    tick;
    drive(1, 8'h33, 8'h44, 2'b00);
    tick;
    drive(1, 8'h55, 8'h66, 2'b00);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL bp_occ got %0d want 2", occupancy); end
    n_cmp++; if ({out_valid, out_a, out_b} !== {1'b1, 8'h11, 8'h22}) begin n_bad++; $display("FAIL bp_head got v=%b a=%h b=%h want v=1 a=11 b=22", out_valid, out_a, out_b); end
    tick;
    n_cmp++; if ({out_valid, out_a, out_b, in_ready} !== {1'b1, 8'h11, 8'h22, 1'b0}) begin n_bad++; $display("FAIL bp_hold got v=%b a=%h b=%h rdy=%b want v=1 a=11 b=22 rdy=0", out_valid, out_a, out_b, in_ready); end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick;
    drive(0, 0, 0, 0);
    n_cmp++; if ({out_valid, out_a, out_b, occupancy} !== {1'b1, 8'h33, 8'h44, 2'd2}) begin n_bad++; $display("FAIL bp_second got v=%b a=%h b=%h occ=%0d want v=1 a=33 b=44 occ=2", out_valid, out_a, out_b, occupancy); end
    tick;
    n_cmp++; if ({out_valid, out_a, out_b} !== {1'b1, 8'h55, 8'h66}) begin n_bad++; $display("FAIL bp_third got v=%b a=%h b=%h want v=1 a=55 b=66", out_valid, out_a, out_b); end
    tick;
    n_cmp++; if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin n_bad++; $display("FAIL bp_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask
  task automatic test_mode_change;
    out_ready = 1;
    drive(1, 8'hF0, 8'h3C, 2'b11);
    tick;
    drive(1, 8'hF0, 8'h3C, 2'b01);
    tick;
    drive(0, 0, 0, 0);
    n_cmp++; if ({out_valid, out_b, out_mode} !== {1'b1, 8'h3C, 2'b11}) begin n_bad++; $display("FAIL inflight_xor got v=%b b=%h m=%b want v=1 b=3c m=11", out_valid, out_b, out_mode); end
    tick;
    n_cmp++; if ({out_valid, out_b, out_mode} !== {1'b1, 8'h30, 2'b01}) begin n_bad++; $display("FAIL inflight_and got v=%b b=%h m=%b want v=1 b=30 m=01", out_valid, out_b, out_mode); end
    tick;
  endtask
  task automatic test_flush;
    out_ready = 0;
    drive(1, 8'h01, 8'h02, 2'b00);
    tick;
    drive(1, 8'h03, 8'h04, 2'b00);
    tick;
    n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_full_occ got %0d want 2", occupancy); end
    flush = 1;
    drive(1, 8'hAA, 8'hBB, 2'b00);
    tick;
    flush = 0;
    drive(0, 0, 0, 0);
    n_cmp++; if ({out_valid, occupancy, in_ready} !== {1'b0, 2'd0, 1'b1}) begin n_bad++; $display("FAIL flush_clear got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=1", out_valid, occupancy, in_ready); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost_%0d got v=%b a=%h want v=0", i, out_valid, out_a); end
    end
  endtask
  task automatic test_reset_mid;
    out_ready = 1;
    drive(1, 8'h77, 8'h88, 2'b00);
    tick;
    drive(1, 8'h99, 8'h66, 2'b00);
    tick;
    drive(0, 0, 0, 0);
    n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL rmid_occ_before got %0d want 2", occupancy); end
    rst_n = 0;
    tick;
    rst_n = 1;
    n_cmp++; if ({out_valid, occupancy} !== {1'b0, 2'd0}) begin n_bad++; $display("FAIL rmid_clear got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_stale_%0d got v=%b a=%h want v=0", i, out_valid, out_a); end
    end
  endtask
  initial begin
    test_reset;
    test_all_modes;
    test_backpressure;
    test_mode_change;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
